// File: rtl/clock_monitor_pkg.sv
// clock_monitor_pkg: monitor state type and helpers deriving the expected timing figures
package clock_monitor_pkg;

  typedef enum logic [1:0] {IDLE, ALIGN, HIGH, LOW} state_e;

  function automatic int h_exp(input int clock_period, input int cycle_time);
    return clock_period / cycle_time / 2;
  endfunction

  function automatic int p_exp(input int clock_period, input int cycle_time);
    return 2 * h_exp(clock_period, cycle_time);
  endfunction

  function automatic int timeout(input int clock_period, input int cycle_time);
    return 4 * h_exp(clock_period, cycle_time);
  endfunction

  function automatic int cnt_w(input int clock_period, input int cycle_time);
    return $clog2(timeout(clock_period, cycle_time) + 1);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchronizer for an async input with rise/fall detection
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // shift the input through the synchronizer and keep one cycle of history behind it
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // both edges see the same pipeline depth, so high time and period are unbiased
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/divided_clock_monitor.sv
// divided_clock_monitor: measures high time and period of a slow clock and reports lock, error and stall
module divided_clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter  int CLOCK_PERIOD = 1000,
  parameter  int CYCLE_TIME   = 10,
  parameter  int TOLERANCE    = 2,
  parameter  int LOCK_COUNT   = 4,
  parameter  int SYNC_STAGES  = 2,
  localparam int CNT_W        = cnt_w(CLOCK_PERIOD, CYCLE_TIME)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clk_in,
  output logic             measure_valid,
  output logic [CNT_W-1:0] period_count,
  output logic [CNT_W-1:0] high_count,
  output logic             locked,
  output logic             freq_error,
  output logic             stalled
);

  localparam int H_EXP   = h_exp(CLOCK_PERIOD, CYCLE_TIME);
  localparam int P_EXP   = p_exp(CLOCK_PERIOD, CYCLE_TIME);
  localparam int TIMEOUT = timeout(CLOCK_PERIOD, CYCLE_TIME);
  localparam int RUN_W   = $clog2(LOCK_COUNT + 1);

  localparam logic        [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic signed [CNT_W:0]   P_S     = (CNT_W+1)'(P_EXP);
  localparam logic signed [CNT_W:0]   H_S     = (CNT_W+1)'(H_EXP);
  localparam logic signed [CNT_W:0]   TOL_S   = (CNT_W+1)'(TOLERANCE);
  localparam logic        [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_COUNT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   high_latch_q, high_latch_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               stalled_q, stalled_d;
  logic               rise, fall, good, timeout_hit;
  logic signed [CNT_W:0] dp, dh;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .din (clk_in),
    .rise(rise),
    .fall(fall)
  );

  // signed distance of the period ending now and its latched high time from nominal
  always_comb begin
    dp          = $signed({1'b0, cnt_q}) - P_S;
    dh          = $signed({1'b0, high_latch_q}) - H_S;
    good        = (dp <= TOL_S) && (dp >= -TOL_S) && (dh <= TOL_S) && (dh >= -TOL_S);
    timeout_hit = (cnt_q == TMO) && !rise && !fall;
  end

  // measurement FSM: enable dominates, then timeout, then edge-driven state moves
  always_comb begin
    state_d      = state_q;
    cnt_d        = rise ? CNT_W'(1) : (cnt_q == TMO ? cnt_q : cnt_q + CNT_W'(1));
    high_latch_d = high_latch_q;
    period_d     = period_q;
    high_d       = high_q;
    run_d        = run_q;
    valid_d      = 1'b0;
    ferr_d       = 1'b0;
    stalled_d    = stalled_q & ~rise;
    if (!enable) begin
      state_d   = IDLE;
      cnt_d     = '0;
      run_d     = '0;
      stalled_d = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = ALIGN;
      cnt_d   = '0;
    end else if (timeout_hit) begin
      state_d   = ALIGN;
      run_d     = '0;
      stalled_d = 1'b1;
    end else if (state_q == ALIGN && rise) begin
      state_d = HIGH;
    end else if (state_q == HIGH && fall) begin
      state_d      = LOW;
      high_latch_d = cnt_q;
    end else if (state_q == LOW && rise) begin
      state_d  = HIGH;
      period_d = cnt_q;
      high_d   = high_latch_q;
      valid_d  = 1'b1;
      ferr_d   = ~good;
      run_d    = !good ? '0 : (run_q == RUN_MAX ? run_q : run_q + RUN_W'(1));
    end
  end

  // state and registered outputs; reset clears everything at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      high_latch_q <= '0;
      period_q     <= '0;
      high_q       <= '0;
      run_q        <= '0;
      valid_q      <= 1'b0;
      ferr_q       <= 1'b0;
      stalled_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      high_latch_q <= high_latch_d;
      period_q     <= period_d;
      high_q       <= high_d;
      run_q        <= run_d;
      valid_q      <= valid_d;
      ferr_q       <= ferr_d;
      stalled_q    <= stalled_d;
    end
  end

  assign measure_valid = valid_q;
  assign period_count  = period_q;
  assign high_count    = high_q;
  assign locked        = (run_q == RUN_MAX);
  assign freq_error    = ferr_q;
  assign stalled       = stalled_q;

endmodule

// File: tb/tb_divided_clock_monitor.sv
// tb_divided_clock_monitor: randomized self-checking bench against a period-level reference model
module tb_divided_clock_monitor;

  typedef struct packed {
    logic [7:0] p;
    logic [7:0] h;
    logic       fe;
    logic       lk;
  } meas_t;

  logic       clk = 1'b0, rst = 1'b1, enable = 1'b0, clk_in = 1'b0;
  logic       measure_valid, locked, freq_error, stalled;
  logic [7:0] period_count, high_count;

  int    checks = 0, errors = 0, stray_fe = 0;
  meas_t got_q[$], exp_q[$];
  meas_t g, e;
  int    run = 0, pend_h = 0, pend_l = 0;
  bit    have_pend = 0;
  logic [7:0] last_p = '0;

  divided_clock_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .clk_in       (clk_in),
    .measure_valid(measure_valid),
    .period_count (period_count),
    .high_count   (high_count),
    .locked       (locked),
    .freq_error   (freq_error),
    .stalled      (stalled)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (measure_valid) got_q.push_back({period_count, high_count, freq_error, locked});
    else if (freq_error) stray_fe++;
  end

  function automatic string fmt(input meas_t m);
    return $sformatf("p=%0d h=%0d fe=%0b lk=%0b", m.p, m.h, m.fe, m.lk);
  endfunction

  // a rising edge closes the pending period: judge it and predict the report
  task automatic model_rise(input int h, input int l);
    if (have_pend) begin
      int p;
      bit ok;
      p   = pend_h + pend_l;
      ok  = (p - 100 <= 2) && (p - 100 >= -2) && (pend_h - 50 <= 2) && (pend_h - 50 >= -2);
      run = ok ? (run < 4 ? run + 1 : 4) : 0;
      exp_q.push_back({8'(p), 8'(pend_h), !ok, run == 4});
      last_p = 8'(p);
    end
    pend_h    = h;
    pend_l    = l;
    have_pend = 1;
  endtask

  task automatic drive_period(input int h, input int l);
    model_rise(h, l);
    clk_in = 1'b1;
    repeat (h) @(negedge clk);
    clk_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enable = 1'b0;
    clk_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({measure_valid, locked, freq_error, stalled, period_count, high_count} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b lk=%0b fe=%0b st=%0b p=%0d h=%0d exp all 0",
               measure_valid, locked, freq_error, stalled, period_count, high_count);
    end
    rst = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_nominal;
    repeat (8) drive_period(50, 50);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : meas_t'('1);
      checks++;
      if (g !== e) begin errors++; $display("FAIL nominal_meas got %s exp %s", fmt(g), fmt(e)); end
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL nominal_extra got %0d exp 0", got_q.size()); got_q.delete(); end
    checks++;
    if (stalled !== 1'b0) begin errors++; $display("FAIL nominal_stalled got %0b exp 0", stalled); end
  endtask

  task automatic test_error_relock;
    drive_period(53, 50);
    repeat (5) drive_period(50, 50);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : meas_t'('1);
      checks++;
      if (g !== e) begin errors++; $display("FAIL relock_meas got %s exp %s", fmt(g), fmt(e)); end
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL relock_extra got %0d exp 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_boundary;
    drive_period(52, 50);
    drive_period(53, 50);
    drive_period(48, 52);
    drive_period(50, 50);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : meas_t'('1);
      checks++;
      if (g !== e) begin errors++; $display("FAIL boundary_meas got %s exp %s", fmt(g), fmt(e)); end
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL boundary_extra got %0d exp 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_random;
    repeat (20) drive_period($urandom_range(46, 54), $urandom_range(46, 54));
    drive_period(50, 50);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : meas_t'('1);
      checks++;
      if (g !== e) begin errors++; $display("FAIL random_meas got %s exp %s", fmt(g), fmt(e)); end
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL random_extra got %0d exp 0", got_q.size()); got_q.delete(); end
    checks++;
    if (stray_fe != 0) begin errors++; $display("FAIL random_stray_ferr got %0d exp 0", stray_fe); end
  endtask

  task automatic test_stall;
    int n, k;
    repeat (5) drive_period(50, 50);
    model_rise(50, 0);
    clk_in = 1'b1;
    n = 0;
    while (!measure_valid && n < 20) begin @(negedge clk); n++; end
    k = 0;
    while (!stalled && k < 400) begin
      @(negedge clk);
      k++;
      if (k == 45) clk_in = 1'b0;
    end
    checks++;
    if (k != 200) begin errors++; $display("FAIL stall_delay got %0d cycles exp 200", k); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL stall_locked got %0b exp 0", locked); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : meas_t'('1);
      checks++;
      if (g !== e) begin errors++; $display("FAIL stall_meas got %s exp %s", fmt(g), fmt(e)); end
    end
    have_pend = 0;
    run = 0;
    repeat (20) @(negedge clk);
    checks++;
    if (stalled !== 1'b1) begin errors++; $display("FAIL stall_hold got %0b exp 1", stalled); end
    drive_period(50, 50);
    checks++;
    if (stalled !== 1'b0) begin errors++; $display("FAIL stall_clear got %0b exp 0", stalled); end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL stall_early_valid got %0d exp 0", got_q.size()); got_q.delete(); end
    repeat (5) drive_period(50, 50);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : meas_t'('1);
      checks++;
      if (g !== e) begin errors++; $display("FAIL restart_meas got %s exp %s", fmt(g), fmt(e)); end
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL restart_extra got %0d exp 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_reset_mid;
    repeat (5) drive_period(50, 50);
    drive_period(50, 20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : meas_t'('1);
      checks++;
      if (g !== e) begin errors++; $display("FAIL prereset_meas got %s exp %s", fmt(g), fmt(e)); end
    end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL prereset_locked got %0b exp 1", locked); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({measure_valid, locked, freq_error, stalled, period_count, high_count} !== 20'd0) begin
      errors++;
      $display("FAIL midreset_outputs got v=%0b lk=%0b fe=%0b st=%0b p=%0d h=%0d exp all 0",
               measure_valid, locked, freq_error, stalled, period_count, high_count);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    have_pend = 0;
    run = 0;
    got_q.delete();
    repeat (5) @(negedge clk);
    repeat (6) drive_period(50, 50);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : meas_t'('1);
      checks++;
      if (g !== e) begin errors++; $display("FAIL postreset_meas got %s exp %s", fmt(g), fmt(e)); end
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL postreset_extra got %0d exp 0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_enable;
    repeat (5) drive_period(50, 50);
    drive_period(50, 30);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL disable_locked got %0b exp 0", locked); end
    repeat (10) @(negedge clk);
    checks++;
    if (period_count !== last_p) begin errors++; $display("FAIL disable_period got %0d exp %0d", period_count, last_p); end
    checks++;
    if (stalled !== 1'b0) begin errors++; $display("FAIL disable_stalled got %0b exp 0", stalled); end
    enable = 1'b1;
    have_pend = 0;
    run = 0;
    repeat (5) @(negedge clk);
    repeat (3) drive_period(50, 50);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : meas_t'('1);
      checks++;
      if (g !== e) begin errors++; $display("FAIL reenable_meas got %s exp %s", fmt(g), fmt(e)); end
    end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL reenable_extra got %0d exp 0", got_q.size()); got_q.delete(); end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_error_relock;
    test_boundary;
    test_random;
    test_stall;
    test_reset_mid;
    test_enable;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divided_clock_monitor.md
Name: divided_clock_monitor

Overview:
- Receive-side companion to the clock divider: watches a divided clock (clk_in) and measures its high time and period in system clk cycles.
- Checks each full period against the expected CLOCK_PERIOD/CYCLE_TIME figures and reports lock, frequency error and stall.
- Sits beside any divider output, or on an externally generated slow clock, as a health monitor feeding status logic.

Parameters:
- CLOCK_PERIOD, 1000, expected period of clk_in in ns.
- CYCLE_TIME, 10, period of clk in ns.
- TOLERANCE, 2, allowed deviation in clk cycles, applied separately to high time and period.
- LOCK_COUNT, 4, consecutive in-tolerance periods required before locked asserts.
- SYNC_STAGES, 2, synchronizer depth for clk_in (minimum 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  monitor runs while high.
- clk_in  input  1  divided clock under test; asynchronous to clk.
- measure_valid  output  1  one-cycle pulse; period_count and high_count updated.
- period_count  output  CNT_W  last measured rise-to-rise period in clk cycles.
- high_count  output  CNT_W  last measured rise-to-fall high time in clk cycles.
- locked  output  1  LOCK_COUNT consecutive good periods seen, no error since.
- freq_error  output  1  one-cycle pulse on an out-of-tolerance period.
- stalled  output  1  level; no rising edge within TIMEOUT cycles.

Behaviour:
- Derived constants:
  - H_EXP = CLOCK_PERIOD/CYCLE_TIME/2.
  - P_EXP = 2*H_EXP.
  - TIMEOUT = 4*H_EXP.
  - CNT_W = $clog2(TIMEOUT+1).
- Reset: all outputs and registers are 0, the synchronizer is cleared, state is IDLE.
- Input path:
  - clk_in passes through SYNC_STAGES flops, then one edge-history flop.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Latency from clk_in edge to detect is SYNC_STAGES+1 cycles, identical for both edges, so measurements are unbiased.
- Counter cnt:
  - On a rise-detect cycle, cnt <= 1; otherwise cnt <= cnt+1.
  - cnt saturates at TIMEOUT.
  - For an ideal input, cnt reads H_EXP on the fall-detect cycle and P_EXP on the next rise-detect cycle.
- States:
  - IDLE: counters are held at 0. When enable=1, go to ALIGN.
  - ALIGN: wait for rise, then go to HIGH. No measurement is reported, because partial periods are discarded.
  - HIGH: on fall, high_latch <= cnt and go to LOW.
  - LOW: on rise, period_count <= cnt, high_count <= high_latch, and go to HIGH.
    - measure_valid pulses on the cycle after the rise (outputs are registered).
- Check, evaluated with the valid pulse:
  - good = |period-P_EXP| <= TOLERANCE and |high-H_EXP| <= TOLERANCE.
  - Differences are computed in signed CNT_W+1 bits.
  - Good period: the lock run counter increments, saturating at LOCK_COUNT; locked = (run == LOCK_COUNT).
  - Bad period: freq_error pulses, run <= 0, and locked drops in the same cycle as measure_valid.
- Timeout:
  - In ALIGN, HIGH or LOW, cnt == TIMEOUT without a rise sets stalled=1, locked=0, run=0, and the state goes to ALIGN.
  - stalled clears on the next rise detect.
- Simultaneous events:
  - An edge detect and the timeout in the same cycle: the edge wins and no stall is flagged.
  - rise and fall cannot both assert in one cycle.
- Enable low in any state:
  - Go to IDLE on the next cycle; locked, stalled and run are cleared.
  - period_count and high_count are retained.
  - Re-enable always restarts from ALIGN.
- Async reset mid-measurement: all outputs go to 0 immediately, with no valid pulse. After release, the state is IDLE.
- Glitches: a glitch of at least one synchronized cycle is measured as a normal period and flagged by the tolerance check. There is no filtering.

Decomposition:
- Package clock_monitor_pkg:
  - state enum (IDLE, ALIGN, HIGH, LOW).
  - functions computing H_EXP, P_EXP, TIMEOUT and CNT_W from the parameters.
- Sub-module sync_edge_detect:
  - SYNC_STAGES synchronizer plus edge-history flop.
  - Outputs rise and fall.
  - Reusable for other asynchronous inputs.

Test Plan:
All scenarios use the defaults: H_EXP=50, P_EXP=100, TIMEOUT=200.
- clk_in 50 high / 50 low continuously -> measure_valid every 100 cycles with period_count=100 and high_count=50; locked rises with the 4th valid; freq_error never pulses.
- Locked, then one period of 53 high / 50 low -> valid with high_count=53 and period_count=103; freq_error pulses and locked drops the same cycle; locked returns after 4 further good periods.
- Boundary: 52/50 (period 102, high 52) -> accepted; 53/50 -> rejected; 48/52 -> accepted.
- clk_in held low after a rise -> stalled=1 exactly 200 cycles after that rise detect, locked=0. Restart clk_in -> stalled clears on the first rise, with no valid until the following rise.
- rst asserted mid-LOW while locked -> all outputs 0 immediately. After release with enable=1, the first valid comes only after ALIGN plus one full period.
- enable dropped while locked -> locked=0 next cycle, period_count=100 retained; re-enable -> no valid until one full aligned period.
